mem_stage_cached: RTL and testbench
===================================

MEM_STAGE_CACHED -- requirements
Module: mem_stage_cached

Interface
REQ-001 Parameter WORD_W, 32: pipeline data word width; SHALL be a multiple of SRAM_DW.
REQ-002 Parameter SRAM_DW, 16: SRAM data bus width; BEATS = WORD_W/SRAM_DW.
REQ-003 Parameter SRAM_AW, 18: SRAM address width.
REQ-004 Parameter WAIT_CYC, 1: clock cycles per SRAM beat, >=1.
REQ-005 Parameter LINES, 64: direct-mapped cache lines, one word each, power of two.
REQ-006 Parameter BASE_ADDR, 1024: byte address mapped to SRAM word 0.
REQ-007 One clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-008 pcIn input 32, PC pass-through; ALU_result input 32, byte address / ALU value; wb_en input 1; mem_read input 1; mem_write input 1; dest input 5; reg2 input WORD_W, store data.
REQ-009 SRAM_DQ inout SRAM_DW; SRAM_ADDR output SRAM_AW; SRAM_WE_N output 1, active-low write strobe.
REQ-010 pcOut output 32; ALU_result_out output 32; wb_en_out output 1; mem_read_out output 1; dest_out output 5; mem_result output WORD_W, load data; freeze output 1, pipeline stall request.

Function
REQ-011 pcOut, ALU_result_out, mem_read_out, dest_out SHALL equal their inputs combinationally; wb_en_out = wb_en AND NOT freeze.
REQ-012 Word address = (ALU_result - BASE_ADDR) >> 2, truncated modulo 2^SRAM_AW/BEATS; beat b uses SRAM_ADDR = word_addr*BEATS + b; beat 0 carries the least significant SRAM_DW bits.
REQ-013 Cache index = word_addr mod LINES; tag = remaining word_addr bits; one valid bit per line.
REQ-014 FSM states: IDLE, RD_BEAT, WR_BEAT, DONE.
REQ-015 IDLE, mem_write=1: freeze=1 combinationally; next state WR_BEAT (mem_write has priority over mem_read when both are 1).
REQ-016 IDLE, mem_read=1, cache hit: freeze=0, mem_result = line data combinationally in the same cycle; no SRAM access; stay in IDLE.
REQ-017 IDLE, mem_read=1, miss: freeze=1; next state RD_BEAT.
REQ-018 RD_BEAT/WR_BEAT: beat counter 0..BEATS-1, wait counter 0..WAIT_CYC-1; each beat holds SRAM_ADDR for WAIT_CYC cycles; freeze=1 throughout.
REQ-019 WR_BEAT: SRAM_WE_N=0 and SRAM_DQ driven with the beat slice of reg2 for all WAIT_CYC cycles of each beat.
REQ-020 RD_BEAT: SRAM_DQ high-Z, SRAM_WE_N=1; DQ sampled into the beat slice of a holding register on the edge ending the beat's last wait cycle.
REQ-021 After the last beat, next state DONE: freeze=0 for exactly one cycle, mem_result = holding register (read) and the FSM returns to IDLE; total freeze = 1 + BEATS*WAIT_CYC cycles.
REQ-022 Read miss SHALL fill the indexed line (data, tag, valid=1) on entry to DONE, evicting any prior occupant.
REQ-023 Write is write-through, no-write-allocate: on a hit the line data is updated on entry to DONE; on a miss the cache is unchanged.
REQ-024 Outside WR_BEAT: SRAM_WE_N=1, SRAM_DQ high-Z; SRAM_ADDR SHALL be 0 in IDLE and DONE.
REQ-025 mem_result SHALL be 0 in IDLE when no read is presented.
REQ-026 Inputs SHALL be held stable by the pipeline while freeze=1; the block does not latch the request.

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, clear all counters, clear all valid bits and the holding register, regardless of the current state.
REQ-028 During and after reset: freeze=0, SRAM_WE_N=1, SRAM_DQ high-Z, SRAM_ADDR=0, mem_result=0.
REQ-029 A transfer interrupted by reset SHALL NOT complete or update the cache; partially written SRAM content is undefined.

Verification (WORD_W=32, SRAM_DW=16, WAIT_CYC=1, LINES=64, BASE_ADDR=1024)
REQ-030 Write 0x12345678 to 1024 -> freeze high 3 cycles; SRAM[0]=0x5678, SRAM[1]=0x1234, WE_N low 2 cycles; wb_en_out low while frozen.
REQ-031 Read 1024 (miss) -> freeze high 3 cycles, DONE cycle mem_result=0x12345678; repeat read -> freeze=0, same-cycle mem_result=0x12345678, no SRAM activity.
REQ-032 Write 0xCAFEF00D to 1024 (hit) then read 1024 -> SRAM updated; read hits, returns 0xCAFEF00D with no freeze.
REQ-033 Read 1280 (same index, new tag) -> miss, evicts line; next read 1024 -> miss, 3-cycle freeze.
REQ-034 mem_read=mem_write=1 at 1028, reg2=0xAAAA5555 -> write performed (SRAM[2]=0x5555, SRAM[3]=0xAAAA), mem_result=0 in DONE.
REQ-035 rst during a read miss RD_BEAT beat 1 -> next cycle freeze=0, WE_N=1; subsequent read 1024 misses.

Source files
------------

// File: rtl/mem_stage_cached.sv
// Memory pipeline stage: a direct-mapped, write-through, one-word-per-line cache in front of a
// narrow asynchronous SRAM. Misses and all stores freeze the pipeline while SRAM beats run.
module mem_stage_cached #(
   parameter int WORD_W    = 32,
   parameter int SRAM_DW   = 16,
   parameter int SRAM_AW   = 18,
   parameter int WAIT_CYC  = 1,
   parameter int LINES     = 64,
   parameter int BASE_ADDR = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        pcIn,
   input  logic [31:0]        ALU_result,
   input  logic               wb_en,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [4:0]         dest,
   input  logic [WORD_W-1:0]  reg2,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic [31:0]        pcOut,
   output logic [31:0]        ALU_result_out,
   output logic               wb_en_out,
   output logic               mem_read_out,
   output logic [4:0]         dest_out,
   output logic [WORD_W-1:0]  mem_result,
   output logic               freeze
);

   localparam int BEATS  = WORD_W / SRAM_DW;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
   localparam int WA_W   = SRAM_AW - $clog2(BEATS);
   localparam int IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;
   localparam int TAG_W  = WA_W - IDX_W;

   typedef enum logic [1:0] {IDLE, RD_BEAT, WR_BEAT, DONE} state_t;

   state_t              state;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [WORD_W-1:0]   hold;
   logic                op_read;

   logic [LINES-1:0]    valid;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [WORD_W-1:0]   data_mem [LINES];

   logic [31:0]         offset;
   logic [WA_W-1:0]     word_addr;
   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic                hit;
   logic                in_xfer;
   logic                last_wait;
   logic                last_beat;
   logic                xfer_end;
   logic                drive;
   logic [SRAM_AW-1:0]  beat_addr;
   logic [WORD_W-1:0]   fill_word;
   logic [SRAM_DW-1:0]  wr_slice;
   logic                freeze_c;
   logic [WORD_W-1:0]   result_c;

   // Word address wraps within the SRAM; addresses below BASE_ADDR land at the top.
   assign offset    = ALU_result - 32'(BASE_ADDR);
   assign word_addr = WA_W'(offset >> 2);
   assign idx       = word_addr[IDX_W-1:0];
   assign tag       = word_addr[WA_W-1:IDX_W];
   assign hit       = valid[idx] && (tag_mem[idx] == tag);

   assign in_xfer   = (state == RD_BEAT) || (state == WR_BEAT);
   assign last_wait = (wait_cnt == WAIT_W'(WAIT_CYC - 1));
   assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
   assign xfer_end  = in_xfer && last_wait && last_beat;
   assign beat_addr = SRAM_AW'(word_addr) * SRAM_AW'(BEATS) + SRAM_AW'(beat_cnt);

   // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      fill_word = hold;
      wr_slice  = '0;
      for (int b = 0; b < BEATS; b++) begin
         if (beat_cnt == BEAT_W'(b)) begin
            fill_word[b*SRAM_DW +: SRAM_DW] = SRAM_DQ;
            wr_slice = reg2[b*SRAM_DW +: SRAM_DW];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         beat_cnt <= '0;
         wait_cnt <= '0;
         hold     <= '0;
         op_read  <= 1'b0;
         valid    <= '0;
      end else begin
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               wait_cnt <= '0;
               if (mem_write) begin
                  state   <= WR_BEAT;
                  op_read <= 1'b0;
               end else if (mem_read && !hit) begin
                  state   <= RD_BEAT;
                  op_read <= 1'b1;
               end
            end
            RD_BEAT, WR_BEAT: begin
               if (last_wait) begin
                  wait_cnt <= '0;
                  if (state == RD_BEAT) hold <= fill_word;
                  if (last_beat) begin
                     beat_cnt <= '0;
                     state    <= DONE;
                     if (state == RD_BEAT) valid[idx] <= 1'b1;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: tag and data arrays carry no reset; the valid bits alone decide whether a line is usable.
   always_ff @(posedge clk) begin
      if (!rst && xfer_end) begin
         if (state == RD_BEAT) begin
            data_mem[idx] <= fill_word;
            tag_mem[idx]  <= tag;
         end else if (hit) begin
            data_mem[idx] <= reg2;
         end
      end
   end

   always_comb begin
      freeze_c = 1'b0;
      result_c = '0;
      case (state)
         IDLE: begin
            freeze_c = mem_write | (mem_read & ~hit);
            if (mem_read && !mem_write && hit) result_c = data_mem[idx];
         end
         RD_BEAT, WR_BEAT: freeze_c = 1'b1;
         DONE:             if (op_read) result_c = hold;
         default:          freeze_c = 1'b0;
      endcase
   end

   // Reset silences the stage immediately, even before the edge that returns the FSM to IDLE.
   assign freeze     = freeze_c & ~rst;
   assign mem_result = rst ? '0 : result_c;
   assign drive      = (state == WR_BEAT) && !rst;
   assign SRAM_WE_N  = ~drive;
   assign SRAM_DQ    = drive ? wr_slice : {SRAM_DW{1'bz}};
   assign SRAM_ADDR  = (in_xfer && !rst) ? beat_addr : '0;

   assign pcOut          = pcIn;
   assign ALU_result_out = ALU_result;
   assign mem_read_out   = mem_read;
   assign dest_out       = dest;
   assign wb_en_out      = wb_en & ~freeze;

endmodule

// File: tb/tb_mem_stage_cached.sv
// Bench for mem_stage_cached: directed scenarios then random loads/stores, checked against a
// word-level cache/memory model and a behavioural SRAM.
module tb_mem_stage_cached;

   localparam int WORD_W    = 32;
   localparam int SRAM_DW   = 16;
   localparam int SRAM_AW   = 18;
   localparam int WAIT_CYC  = 1;
   localparam int LINES     = 64;
   localparam int BASE_ADDR = 1024;
   localparam int BEATS     = WORD_W / SRAM_DW;
   localparam int WORDS     = (1 << SRAM_AW) / BEATS;

   logic               clk = 1'b0;
   logic               rst;
   logic [31:0]        pcIn, ALU_result;
   logic               wb_en, mem_read, mem_write;
   logic [4:0]         dest;
   logic [WORD_W-1:0]  reg2;
   wire  [SRAM_DW-1:0] SRAM_DQ;
   logic [SRAM_AW-1:0] SRAM_ADDR;
   logic               SRAM_WE_N;
   logic [31:0]        pcOut, ALU_result_out;
   logic               wb_en_out, mem_read_out, freeze;
   logic [4:0]         dest_out;
   logic [WORD_W-1:0]  mem_result;

   int errors = 0;
   int checks = 0;

   // Reference model: cache lines hold the full word address as their tag.
   bit          ref_valid [LINES];
   int          ref_tag   [LINES];
   logic [31:0] ref_data  [LINES];
   logic [31:0] exp_words [int];

   // Behavioural SRAM: unwritten locations return an address-derived pattern.
   logic [SRAM_DW-1:0] sram_mem [0:(1<<SRAM_AW)-1];
   bit                 sram_wr  [0:(1<<SRAM_AW)-1];
   logic [SRAM_DW-1:0] tb_dq;

   mem_stage_cached #(
      .WORD_W(WORD_W), .SRAM_DW(SRAM_DW), .SRAM_AW(SRAM_AW),
      .WAIT_CYC(WAIT_CYC), .LINES(LINES), .BASE_ADDR(BASE_ADDR)
   ) dut (
      .clk(clk), .rst(rst), .pcIn(pcIn), .ALU_result(ALU_result), .wb_en(wb_en),
      .mem_read(mem_read), .mem_write(mem_write), .dest(dest), .reg2(reg2),
      .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
      .pcOut(pcOut), .ALU_result_out(ALU_result_out), .wb_en_out(wb_en_out),
      .mem_read_out(mem_read_out), .dest_out(dest_out), .mem_result(mem_result),
      .freeze(freeze)
   );

   always #5 clk = ~clk;

   function automatic logic [SRAM_DW-1:0] init_half(input int a);
      logic [31:0] h;
      h = 32'(a) * 32'h9E3779B1;
      return h[26:11];
   endfunction

   function automatic logic [SRAM_DW-1:0] sram_rd(input int a);
      return sram_wr[a] ? sram_mem[a] : init_half(a);
   endfunction

   function automatic logic [31:0] mem_word(input int wa);
      if (exp_words.exists(wa)) return exp_words[wa];
      return {init_half(wa*BEATS + 1), init_half(wa*BEATS)};
   endfunction

   always_comb tb_dq = sram_rd(int'(SRAM_ADDR));
   assign SRAM_DQ = SRAM_WE_N ? tb_dq : {SRAM_DW{1'bz}};

   always @(posedge clk) begin
      if (SRAM_WE_N === 1'b0) begin
         sram_mem[SRAM_ADDR] <= SRAM_DQ;
         sram_wr[SRAM_ADDR]  <= 1'b1;
      end
   end

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Called just after a rising edge; leaves just after the rising edge that ends the access.
   task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input string nm);
      logic [31:0] off, exp_res;
      int wa, idx, fz, we_cnt, wb_bad, addr_bad, exp_fz, beat;
      bit line_hit;
      off      = addr - 32'(BASE_ADDR);
      wa       = int'((off >> 2) & 32'(WORDS - 1));
      idx      = wa % LINES;
      line_hit = ref_valid[idx] && (ref_tag[idx] == wa);
      exp_fz   = (wr || (rd && !line_hit)) ? 1 + BEATS*WAIT_CYC : 0;
      exp_res  = (rd && !wr) ? (line_hit ? ref_data[idx] : mem_word(wa)) : 32'h0;

      pcIn = $urandom; dest = 5'($urandom); wb_en = 1'b1;
      ALU_result = addr; reg2 = wdata; mem_read = rd; mem_write = wr;
      fz = 0; we_cnt = 0; wb_bad = 0; addr_bad = 0;
      @(negedge clk);
      check({nm, "_pass"}, {pcOut, ALU_result_out}, {pcIn, ALU_result});
      check({nm, "_ctl"}, {dest_out, mem_read_out}, {dest, mem_read});
      while (freeze === 1'b1 && fz < 20) begin
         if (wb_en_out !== 1'b0) wb_bad++;
         if (fz == 0) begin
            if (SRAM_ADDR !== '0 || SRAM_WE_N !== 1'b1) addr_bad++;
         end else begin
            beat = (fz - 1) / WAIT_CYC;
            if (SRAM_ADDR !== SRAM_AW'(wa*BEATS + beat)) addr_bad++;
            if (SRAM_WE_N === 1'b0) we_cnt++;
         end
         fz++;
         @(negedge clk);
      end
      check({nm, "_freeze_cycles"}, fz, exp_fz);
      check({nm, "_result"}, mem_result, exp_res);
      check({nm, "_we_cycles"}, we_cnt, wr ? BEATS*WAIT_CYC : 0);
      check({nm, "_wb_gate"}, {wb_bad, 31'd0, wb_en_out}, {32'd0, 32'd1});
      check({nm, "_bus_addr"}, addr_bad, 0);
      check({nm, "_done_bus"}, {SRAM_ADDR, SRAM_WE_N}, {{SRAM_AW{1'b0}}, 1'b1});

      if (wr) begin
         exp_words[wa] = wdata;
         if (line_hit) ref_data[idx] = wdata;
         check({nm, "_sram_lo"}, sram_rd(wa*BEATS), wdata[15:0]);
         check({nm, "_sram_hi"}, sram_rd(wa*BEATS + 1), wdata[31:16]);
      end else if (rd && !line_hit) begin
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = wa;
         ref_data[idx]  = mem_word(wa);
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0; wb_en = 1'b0;
   endtask

   task automatic idle_check(input string nm);
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      check({nm, "_result"}, mem_result, 0);
      check({nm, "_bus"}, {freeze, SRAM_WE_N, SRAM_ADDR}, {1'b0, 1'b1, {SRAM_AW{1'b0}}});
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] a, d;
      int kind;
      for (int i = 0; i < LINES; i++) begin
         ref_valid[i] = 1'b0;
         ref_tag[i]   = 0;
         ref_data[i]  = '0;
      end
      rst = 1'b1; pcIn = '0; dest = '0; wb_en = 1'b0; reg2 = '0;
      ALU_result = 32'(BASE_ADDR); mem_read = 1'b1; mem_write = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {freeze, SRAM_WE_N, SRAM_ADDR}, {1'b0, 1'b1, {SRAM_AW{1'b0}}});
      check("reset_result", mem_result, 0);
      rst = 1'b0; mem_read = 1'b0;
      @(posedge clk); #1;

      do_op(0, 1, 32'd1024, 32'h12345678, "w1024");
      do_op(1, 0, 32'd1024, 32'h0,        "r1024_miss");
      check("r1024_miss_value", ref_data[0], 32'h12345678);
      do_op(1, 0, 32'd1024, 32'h0,        "r1024_hit");
      do_op(0, 1, 32'd1024, 32'hCAFEF00D, "w1024_hit");
      do_op(1, 0, 32'd1024, 32'h0,        "r1024_hit2");
      do_op(1, 0, 32'd1280, 32'h0,        "r1280_evict");
      do_op(1, 0, 32'd1024, 32'h0,        "r1024_remiss");
      do_op(1, 1, 32'd1028, 32'hAAAA5555, "rw1028");
      do_op(0, 1, 32'd1020, 32'h0BADBEEF, "w1020_wrap");
      do_op(1, 0, 32'd1022, 32'h0,        "r1020_wrap");
      idle_check("idle1");

      // Reset in the middle of a read miss, during the second beat.
      ALU_result = 32'd1044; mem_read = 1'b1; mem_write = 1'b0; wb_en = 1'b1;
      @(negedge clk);
      check("rst_seq_idle_freeze", freeze, 1);
      @(negedge clk);
      @(negedge clk);
      check("rst_seq_beat1_addr", SRAM_ADDR, 11);
      rst = 1'b1;
      #1;
      check("rst_during", {freeze, SRAM_WE_N, SRAM_ADDR}, {1'b0, 1'b1, {SRAM_AW{1'b0}}});
      @(negedge clk);
      check("rst_after", {freeze, SRAM_WE_N, SRAM_ADDR}, {1'b0, 1'b1, {SRAM_AW{1'b0}}});
      check("rst_after_result", mem_result, 0);
      rst = 1'b0; mem_read = 1'b0; wb_en = 1'b0;
      for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
      @(posedge clk); #1;
      do_op(1, 0, 32'd1024, 32'h0, "r1024_post_rst");
      do_op(1, 0, 32'd1044, 32'h0, "r1044_post_rst");

      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 3));
         a    = 32'(BASE_ADDR) + 32'(4 * $urandom_range(0, 191)) + 32'($urandom_range(0, 3));
         d    = $urandom;
         case (kind)
            0, 1:    do_op(1, 0, a, d, "rnd_rd");
            2:       do_op(0, 1, a, d, "rnd_wr");
            default: do_op(1, 1, a, d, "rnd_rw");
         endcase
      end
      idle_check("idle2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
